// File: rtl/mac_defs.sv
// Shared definitions for the pipelined multiply-accumulate unit: mode encodings,
// arithmetic-type select constants and width helpers.
package mac_defs;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam int ARITH_UNSIGNED = 0;
    localparam int ARITH_SIGNED   = 1;

    function automatic int prod_width(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational accumulator adder: one-bit-wider sum, overflow detection against
// the ACC_W range, and optional clamp to the representable max/min.
module mac_sat_add
    import mac_defs::*;
#(
    parameter int ACC_W    = 16,
    parameter int SIGNED   = ARITH_UNSIGNED,
    parameter int SATURATE = int'(MODE_WRAP)
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [ACC_W-1:0] i_term,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

    localparam logic [ACC_W-1:0] ACC_MAX = (SIGNED == ARITH_SIGNED) ?
        {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] ACC_MIN = (SIGNED == ARITH_SIGNED) ?
        {1'b1, {(ACC_W-1){1'b0}}} : {ACC_W{1'b0}};

    logic [ACC_W:0] w_sum;
    logic           w_neg;

    // NOTE: every output of this block gets a value on every path first, so no latch is inferred.
    always_comb begin
        w_sum = '0;
        w_neg = 1'b0;
        o_ovf = 1'b0;
        if (SIGNED == ARITH_SIGNED) begin
            // The extra bit holds the exact sum; a mismatch with the sign bit means out of range.
            w_sum = {i_acc[ACC_W-1], i_acc} + {i_term[ACC_W-1], i_term};
            o_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
            w_neg = w_sum[ACC_W];
        end else begin
            w_sum = {1'b0, i_acc} + {1'b0, i_term};
            o_ovf = w_sum[ACC_W];
        end
        o_sum = w_sum[ACC_W-1:0];
        if (o_ovf && (SATURATE == int'(MODE_SAT))) begin
            o_sum = w_neg ? ACC_MIN : ACC_MAX;
        end
    end

endmodule

// File: rtl/mac_pipe.sv
// Two-stage pipelined multiply-accumulate: registered product, then accumulate with
// wrap/saturate, sticky overflow, saturating term counter and synchronous clear.
module mac_pipe
    import mac_defs::*;
#(
    parameter int DATA_W   = 4,
    parameter int ACC_W    = 16,
    parameter int SIGNED   = ARITH_UNSIGNED,
    parameter int SATURATE = int'(MODE_WRAP),
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              in_valid,
    input  logic              clr,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    output logic              ovf,
    output logic [CNT_W-1:0]  cnt
);

    localparam int PROD_W = prod_width(DATA_W);

    if (DATA_W < 2) begin : g_bad_data_w
        $error("mac_pipe: DATA_W must be at least 2");
    end
    if (ACC_W < PROD_W) begin : g_bad_acc_w
        $error("mac_pipe: ACC_W must be at least 2*DATA_W");
    end

    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_term;
    logic [ACC_W-1:0]  w_next_acc;
    logic              w_add_ovf;

    logic [PROD_W-1:0] r_prod;
    logic              r_v1;
    logic [ACC_W-1:0]  r_acc;
    logic              r_out_valid;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_cnt;

    if (SIGNED == ARITH_SIGNED) begin : g_signed
        assign w_prod = PROD_W'($signed(data_a)) * PROD_W'($signed(data_b));
        assign w_term = ACC_W'($signed(r_prod));
    end else begin : g_unsigned
        assign w_prod = PROD_W'(data_a) * PROD_W'(data_b);
        assign w_term = ACC_W'(r_prod);
    end

    mac_sat_add #(
        .ACC_W    (ACC_W),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .i_acc  (r_acc),
        .i_term (w_term),
        .o_sum  (w_next_acc),
        .o_ovf  (w_add_ovf)
    );

    // Stage 1 ignores clr so a sample presented alongside clr starts the new accumulation.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_prod <= '0;
            r_v1   <= 1'b0;
        end else begin
            r_prod <= w_prod;
            r_v1   <= in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
        end else if (clr) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
        end else if (r_v1) begin
            r_acc       <= w_next_acc;
            r_out_valid <= 1'b1;
            r_ovf       <= r_ovf | w_add_ovf;
            if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign acc_out   = r_acc;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;
    assign cnt       = r_cnt;

endmodule

// File: tb/tb_mac_pipe.sv
// Scoreboard bench for mac_pipe: five configurations share one stimulus stream and
// are each checked against an independent integer model of the accumulation.
module tb_mac_pipe;

    localparam int NI = 5;
    localparam int ACCW [NI] = '{16, 8, 8, 8, 16};
    localparam bit SGN  [NI] = '{0, 0, 0, 1, 1};
    localparam bit SAT  [NI] = '{0, 0, 1, 1, 0};

    typedef struct {
        longint acc;
        bit     ovf;
        int     cnt;
    } st_t;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       in_valid = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] data_a = '0;
    logic [3:0] data_b = '0;

    logic [15:0] acc0, acc4;
    logic [7:0]  acc1, acc2, acc3;
    logic [NI-1:0] ov_o, ovf_o;
    logic [7:0]  cnt_o [NI];
    logic [15:0] acc_o [NI];

    assign acc_o[0] = acc0;
    assign acc_o[1] = {8'h00, acc1};
    assign acc_o[2] = {8'h00, acc2};
    assign acc_o[3] = {8'h00, acc3};
    assign acc_o[4] = acc4;

    int  n_checks = 0;
    int  n_fail   = 0;
    st_t mdl [NI];
    st_t sb  [NI][$];

    always #5 clk = ~clk;

    mac_pipe #(.DATA_W(4), .ACC_W(16), .SIGNED(0), .SATURATE(0), .CNT_W(8)) u_def (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .clr(clr), .data_a(data_a), .data_b(data_b),
        .acc_out(acc0), .out_valid(ov_o[0]), .ovf(ovf_o[0]), .cnt(cnt_o[0]));
    mac_pipe #(.DATA_W(4), .ACC_W(8), .SIGNED(0), .SATURATE(0), .CNT_W(8)) u_wrap (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .clr(clr), .data_a(data_a), .data_b(data_b),
        .acc_out(acc1), .out_valid(ov_o[1]), .ovf(ovf_o[1]), .cnt(cnt_o[1]));
    mac_pipe #(.DATA_W(4), .ACC_W(8), .SIGNED(0), .SATURATE(1), .CNT_W(8)) u_sat (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .clr(clr), .data_a(data_a), .data_b(data_b),
        .acc_out(acc2), .out_valid(ov_o[2]), .ovf(ovf_o[2]), .cnt(cnt_o[2]));
    mac_pipe #(.DATA_W(4), .ACC_W(8), .SIGNED(1), .SATURATE(1), .CNT_W(8)) u_ssat (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .clr(clr), .data_a(data_a), .data_b(data_b),
        .acc_out(acc3), .out_valid(ov_o[3]), .ovf(ovf_o[3]), .cnt(cnt_o[3]));
    mac_pipe #(.DATA_W(4), .ACC_W(16), .SIGNED(1), .SATURATE(0), .CNT_W(8)) u_sgn (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .clr(clr), .data_a(data_a), .data_b(data_b),
        .acc_out(acc4), .out_valid(ov_o[4]), .ovf(ovf_o[4]), .cnt(cnt_o[4]));

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic st_t step_model(input st_t s, input int i, input logic [3:0] a, input logic [3:0] b);
        longint one = 1;
        int     w = ACCW[i];
        longint mask = (one << w) - 1;
        longint av, bv, accv, sum, mx, mn;
        st_t    r = s;
        if (SGN[i]) begin
            av   = a[3] ? longint'(a) - 16 : longint'(a);
            bv   = b[3] ? longint'(b) - 16 : longint'(b);
            accv = s.acc[w-1] ? s.acc - (one << w) : s.acc;
            mx   = (one << (w - 1)) - 1;
            mn   = -(one << (w - 1));
        end else begin
            av   = longint'(a);
            bv   = longint'(b);
            accv = s.acc;
            mx   = mask;
            mn   = 0;
        end
        sum = accv + av * bv;
        if (sum > mx) begin
            r.ovf = 1'b1;
            r.acc = SAT[i] ? mx : (sum & mask);
        end else if (sum < mn) begin
            r.ovf = 1'b1;
            r.acc = SAT[i] ? (mn & mask) : (sum & mask);
        end else begin
            r.acc = sum & mask;
        end
        if (r.cnt < 255) r.cnt++;
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NI; i++) begin
            mdl[i].acc = 0;
            mdl[i].ovf = 1'b0;
            mdl[i].cnt = 0;
        end
    endtask

    // One cycle of stimulus; drop marks a term that a following clr will discard.
    task automatic cyc(input logic v, input logic c, input logic [3:0] a, input logic [3:0] b, input bit drop);
        in_valid = v;
        clr      = c;
        data_a   = a;
        data_b   = b;
        if (c) model_clear();
        if (v && !drop) begin
            for (int i = 0; i < NI; i++) begin
                mdl[i] = step_model(mdl[i], i, a, b);
                sb[i].push_back(mdl[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_b) begin
            for (int i = 0; i < NI; i++) begin
                if (ov_o[i]) begin
                    if (sb[i].size() == 0) begin
                        check($sformatf("unexpected_out_valid[%0d]", i), 1, 0);
                    end else begin
                        st_t e;
                        e = sb[i].pop_front();
                        check($sformatf("acc[%0d]", i), longint'(acc_o[i]), e.acc);
                        check($sformatf("ovf[%0d]", i), longint'(ovf_o[i]), longint'(e.ovf));
                        check($sformatf("cnt[%0d]", i), longint'(cnt_o[i]), longint'(e.cnt));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_acc", longint'(acc0), 0);
        check("reset_out_valid", longint'(ov_o), 0);
        check("reset_ovf", longint'(ovf_o), 0);
        check("reset_cnt", longint'(cnt_o[0]), 0);
        #3 rst_b = 1'b1;
        @(posedge clk);
        #1;

        // Basic: 15 then 240 on the default configuration.
        cyc(1'b1, 1'b0, 4'd3, 4'd5, 1'b0);
        cyc(1'b1, 1'b0, 4'd15, 4'd15, 1'b0);
        idle(3);
        check("basic_acc", longint'(acc0), 240);
        check("basic_cnt", longint'(cnt_o[0]), 2);
        check("basic_ovf", longint'(ovf_o[0]), 0);

        // Wrap / saturate on 8-bit accumulators.
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
        idle(1);
        check("clr_acc_wrap", longint'(acc1), 0);
        cyc(1'b1, 1'b0, 4'd15, 4'd15, 1'b0);
        cyc(1'b1, 1'b0, 4'd15, 4'd15, 1'b0);
        idle(6);
        check("wrap_acc", longint'(acc1), 194);
        check("wrap_ovf_sticky", longint'(ovf_o[1]), 1);
        check("sat_acc", longint'(acc2), 255);

        // Signed saturation: (-8,-8) three times.
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 4'h8, 4'h8, 1'b0);
        idle(3);
        check("ssat_acc", longint'(acc3), 127);
        check("ssat_ovf", longint'(ovf_o[3]), 1);

        // Signed sign extension: (-8,7) then (3,-2).
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
        cyc(1'b1, 1'b0, 4'h8, 4'h7, 1'b0);
        cyc(1'b1, 1'b0, 4'h3, 4'hE, 1'b0);
        idle(3);
        check("sext_acc", longint'(acc4), 64'hFFC2);
        check("sext_ovf", longint'(ovf_o[4]), 0);

        // clr with a same-cycle term becomes the first term of the new accumulation.
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
        cyc(1'b1, 1'b0, 4'd3, 4'd5, 1'b0);
        cyc(1'b1, 1'b0, 4'd15, 4'd15, 1'b0);
        cyc(1'b1, 1'b0, 4'd15, 4'd15, 1'b0);
        idle(3);
        check("pre_clr_ovf", longint'(ovf_o[1]), 1);
        cyc(1'b1, 1'b1, 4'd2, 4'd3, 1'b0);
        check("clr_acc_zero", longint'(acc0), 0);
        check("clr_ovf_zero", longint'(ovf_o[1]), 0);
        in_valid = 1'b0;
        clr      = 1'b0;
        idle(3);
        check("clr_new_acc", longint'(acc0), 6);
        check("clr_new_cnt", longint'(cnt_o[0]), 1);

        // A term sitting in stage 2 on the clr edge is discarded.
        cyc(1'b1, 1'b0, 4'd1, 4'd1, 1'b1);
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
        idle(3);
        check("drop_acc", longint'(acc0), 0);
        check("drop_cnt", longint'(cnt_o[0]), 0);

        // Random terms through every configuration.
        for (int k = 0; k < 24; k++) begin
            cyc(($urandom_range(0, 3) != 0), 1'b0, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
        end
        idle(3);

        // Asynchronous reset mid-cycle with terms in flight.
        cyc(1'b1, 1'b0, 4'd5, 4'd5, 1'b0);
        idle(3);
        cyc(1'b1, 1'b0, 4'd7, 4'd7, 1'b0);
        in_valid = 1'b0;
        #3 rst_b = 1'b0;
        #1;
        check("async_rst_acc", longint'(acc0), 0);
        check("async_rst_out_valid", longint'(ov_o), 0);
        check("async_rst_ovf", longint'(ovf_o), 0);
        check("async_rst_cnt", longint'(cnt_o[0]), 0);
        for (int i = 0; i < NI; i++) sb[i].delete();
        model_clear();
        @(posedge clk);
        #3 rst_b = 1'b1;
        @(posedge clk);
        #1;
        idle(4);
        check("post_rst_acc", longint'(acc0), 0);

        for (int i = 0; i < NI; i++) begin
            check($sformatf("scoreboard_empty[%0d]", i), longint'(sb[i].size()), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
